// File: rtl/calc_seq_ctrl_if.sv
// rtl/calc_seq_ctrl_if.sv - key/switch inputs, ALU handshake and display bundle for calc_seq_ctrl
//
// Purpose: groups every non-clock/reset signal of the calculator sequencer.
// Signals:
//   in_number[3:0]  switch value sampled on accepted key presses
//   k_1/k_2/k_3     raw keys: capture A, capture B, execute
//   k_clr           raw clear key
//   alu_done        one-cycle ALU completion pulse
//   alu_err         ALU error flag, valid with alu_done
//   alu_result[7:0] ALU result, valid with alu_done
//   reg_1/reg_2     operands A and B
//   op[1:0]         operation code
//   alu_start       one-cycle ALU start pulse
//   result[7:0]     last good result
//   disp_data[7:0]  value routed to the display
//   contr[2:0]      display mode (0 A, 1 B, 2 op, 3 result, 4 error)
//   led[2:0]        progress/status LEDs
// Modports: master = sequencer side, slave = panel/ALU side.
interface calc_seq_ctrl_if;
  logic [3:0] in_number;
  logic       k_1;
  logic       k_2;
  logic       k_3;
  logic       k_clr;
  logic       alu_done;
  logic       alu_err;
  logic [7:0] alu_result;
  logic [3:0] reg_1;
  logic [3:0] reg_2;
  logic [1:0] op;
  logic       alu_start;
  logic [7:0] result;
  logic [7:0] disp_data;
  logic [2:0] contr;
  logic [2:0] led;

  modport master (
    input  in_number, k_1, k_2, k_3, k_clr, alu_done, alu_err, alu_result,
    output reg_1, reg_2, op, alu_start, result, disp_data, contr, led
  );

  modport slave (
    output in_number, k_1, k_2, k_3, k_clr, alu_done, alu_err, alu_result,
    input  reg_1, reg_2, op, alu_start, result, disp_data, contr, led
  );
endinterface

// File: rtl/calc_seq_ctrl.sv
// rtl/calc_seq_ctrl.sv - calculator sequencer: key debounce, operand capture, ALU handshake, display select
//
// Purpose: debounces the four front-panel keys, captures operands and opcode
// from the switches, launches the ALU and routes the display/LEDs.
// Ports:
//   i_clk    system clock, rising edge
//   i_rst_n  asynchronous active-low reset
//   io_bus   calc_seq_ctrl_if.master (keys, switches, ALU handshake, display, LEDs)
module calc_seq_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int TIMEOUT_CYCLES  = 64
) (
  input logic             i_clk,
  input logic             i_rst_n,
  calc_seq_ctrl_if.master io_bus
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {S_A, S_B, S_OP, S_BUSY, S_RES, S_ERR} state_t;

  // Key index: 0 = k_1, 1 = k_2, 2 = k_3, 3 = k_clr
  logic [3:0]    w_raw;
  logic [3:0]    r_sync1;
  logic [3:0]    r_sync2;
  logic [3:0]    r_level;
  logic [3:0]    r_press;
  logic [DW-1:0] r_db_cnt [4];

  assign w_raw = {io_bus.k_clr, io_bus.k_3, io_bus.k_2, io_bus.k_1};

  // r_db_cnt counts consecutive samples that disagree with the accepted
  // level; holding at DEBOUNCE_CYCLES for one cycle flips the level and
  // emits the press pulse on a rising acceptance only.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_level <= '0;
      r_press <= '0;
      for (int i = 0; i < 4; i++) r_db_cnt[i] <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      for (int i = 0; i < 4; i++) begin
        r_press[i] <= 1'b0;
        if (r_db_cnt[i] == DW'(DEBOUNCE_CYCLES)) begin
          r_level[i]  <= ~r_level[i];
          r_press[i]  <= ~r_level[i];
          r_db_cnt[i] <= '0;
        end else if (r_sync2[i] != r_level[i]) begin
          r_db_cnt[i] <= r_db_cnt[i] + DW'(1);
        end else begin
          r_db_cnt[i] <= '0;
        end
      end
    end
  end

  // Same-cycle presses: clear beats k_1 beats k_2 beats k_3
  logic w_clr, w_p1, w_p2, w_p3;
  assign w_clr = r_press[3];
  assign w_p1  = r_press[0] & ~r_press[3];
  assign w_p2  = r_press[1] & ~r_press[3] & ~r_press[0];
  assign w_p3  = r_press[2] & ~r_press[3] & ~r_press[0] & ~r_press[1];

  state_t        r_state, w_state_nxt;
  logic [3:0]    r_reg_1, w_reg_1_nxt;
  logic [3:0]    r_reg_2, w_reg_2_nxt;
  logic [1:0]    r_op, w_op_nxt;
  logic [7:0]    r_result, w_result_nxt;
  logic          r_alu_start, w_alu_start_nxt;
  logic [TW-1:0] r_tmo, w_tmo_nxt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_A;
      r_reg_1     <= '0;
      r_reg_2     <= '0;
      r_op        <= '0;
      r_result    <= '0;
      r_alu_start <= 1'b0;
      r_tmo       <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_reg_1     <= w_reg_1_nxt;
      r_reg_2     <= w_reg_2_nxt;
      r_op        <= w_op_nxt;
      r_result    <= w_result_nxt;
      r_alu_start <= w_alu_start_nxt;
      r_tmo       <= w_tmo_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_reg_1_nxt     = r_reg_1;
    w_reg_2_nxt     = r_reg_2;
    w_op_nxt        = r_op;
    w_result_nxt    = r_result;
    w_alu_start_nxt = 1'b0;
    w_tmo_nxt       = r_tmo;
    if (w_clr) begin
      w_state_nxt  = S_A;
      w_reg_1_nxt  = '0;
      w_reg_2_nxt  = '0;
      w_op_nxt     = '0;
      w_result_nxt = '0;
    end else begin
      case (r_state)
        S_A: begin
          if (w_p1) begin
            w_reg_1_nxt = io_bus.in_number;
            w_state_nxt = S_B;
          end
        end
        S_B: begin
          if (w_p1) begin
            w_reg_1_nxt = io_bus.in_number;
          end else if (w_p2) begin
            w_reg_2_nxt = io_bus.in_number;
            w_state_nxt = S_OP;
          end
        end
        S_OP: begin
          if (w_p3) begin
            w_op_nxt        = io_bus.in_number[1:0];
            w_alu_start_nxt = 1'b1;
            w_tmo_nxt       = '0;
            w_state_nxt     = S_BUSY;
          end else if (w_p2) begin
            w_reg_2_nxt = io_bus.in_number;
          end
        end
        S_BUSY: begin
          // alu_done is ignored in the start cycle itself
          if (!r_alu_start && io_bus.alu_done) begin
            if (io_bus.alu_err) begin
              w_state_nxt = S_ERR;
            end else begin
              w_result_nxt = io_bus.alu_result;
              w_state_nxt  = S_RES;
            end
          end else if (r_tmo == TW'(TIMEOUT_CYCLES - 1)) begin
            w_state_nxt = S_ERR;
          end else begin
            w_tmo_nxt = r_tmo + TW'(1);
          end
        end
        S_RES: begin
          if (w_p1) begin
            w_reg_1_nxt = io_bus.in_number;
            w_state_nxt = S_B;
          end else if (w_p3) begin
            w_op_nxt        = io_bus.in_number[1:0];
            w_alu_start_nxt = 1'b1;
            w_tmo_nxt       = '0;
            w_state_nxt     = S_BUSY;
          end
        end
        S_ERR: begin
          if (w_p1) begin
            w_reg_1_nxt = io_bus.in_number;
            w_state_nxt = S_B;
          end
        end
        default: w_state_nxt = S_A;
      endcase
    end
  end

  logic [2:0] w_contr;
  logic [2:0] w_led;
  logic [7:0] w_disp;

  always_comb begin
    w_contr = 3'd0;
    w_led   = 3'b001;
    case (r_state)
      S_A:     begin w_contr = 3'd0; w_led = 3'b001; end
      S_B:     begin w_contr = 3'd1; w_led = 3'b010; end
      S_OP:    begin w_contr = 3'd2; w_led = 3'b100; end
      S_BUSY:  begin w_contr = 3'd2; w_led = 3'b111; end
      S_RES:   begin w_contr = 3'd3; w_led = 3'b000; end
      S_ERR:   begin w_contr = 3'd4; w_led = 3'b101; end
      default: begin w_contr = 3'd0; w_led = 3'b001; end
    endcase
  end

  always_comb begin
    w_disp = 8'h00;
    case (w_contr)
      3'd0:    w_disp = {4'b0, r_reg_1};
      3'd1:    w_disp = {4'b0, r_reg_2};
      3'd2:    w_disp = {6'b0, r_op};
      3'd3:    w_disp = r_result;
      default: w_disp = 8'h00;
    endcase
  end

  assign io_bus.reg_1     = r_reg_1;
  assign io_bus.reg_2     = r_reg_2;
  assign io_bus.op        = r_op;
  assign io_bus.alu_start = r_alu_start;
  assign io_bus.result    = r_result;
  assign io_bus.disp_data = w_disp;
  assign io_bus.contr     = w_contr;
  assign io_bus.led       = w_led;

endmodule
